// File: rtl/parity_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_serializer
// Description : Takes one DATA_W-bit word per frame over a valid/ready
//               handshake and shifts it out on x LSB-first, one bit per
//               clock. A computed parity bit follows the data bits. Framing
//               strobes mark the active bits, the parity slot and the end of
//               each frame.
// Options     : SER_IDLE_GAP_EN - when defined, din_ready stays low in the
//               parity cycle, so at least one idle bit (x=0) separates
//               consecutive frames. When undefined, a new word can be
//               accepted in the parity cycle and frames run back to back.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_serializer #(
   parameter int DATA_W     = 8,  // data bits per frame, 2..32
   parameter int PARITY_ODD = 0   // 0 = even parity, 1 = odd parity
) (
   input  logic              clk,
   input  logic              reset,        // synchronous, active-low
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              x,
   output logic              frame_active,
   output logic              parity_slot,
   output logic              frame_done
);

   localparam int              CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);
   localparam logic            C_ODD  = (PARITY_ODD != 0);
`ifdef SER_IDLE_GAP_EN
   localparam logic            C_PAR_READY = 1'b0;
`else
   localparam logic            C_PAR_READY = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PAR   = 2'd2
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shreg_q;   // bit 0 is the bit currently on x
   logic [CNT_W-1:0]  cnt_q;     // index of the data bit currently on x
   logic              par_q;     // XOR of the data bits already shifted out
   logic              x_q;
   logic              active_q;
   logic              slot_q;
   logic              done_q;
   logic              ready_q;

   // ready_q is only ever high in IDLE or PAR, so an accept always starts a frame
   logic w_accept;
   assign w_accept = din_valid && ready_q;

   // Frame FSM with all outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         par_q    <= 1'b0;
         x_q      <= 1'b0;
         active_q <= 1'b0;
         slot_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         // Leaving the parity cycle, either way, ends the frame
         done_q <= (state_q == S_PAR);
         if (w_accept) begin
            state_q  <= S_SHIFT;
            shreg_q  <= din;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            x_q      <= din[0];
            active_q <= 1'b1;
            slot_q   <= 1'b0;
            ready_q  <= 1'b0;
         end else begin
            case (state_q)
               S_SHIFT: begin
                  shreg_q <= shreg_q >> 1;
                  par_q   <= par_q ^ shreg_q[0];
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == C_LAST) begin
                     // Last data bit leaves now; parity covers all DATA_W bits
                     state_q <= S_PAR;
                     x_q     <= par_q ^ shreg_q[0] ^ C_ODD;
                     slot_q  <= 1'b1;
                     ready_q <= C_PAR_READY;
                  end else begin
                     x_q <= shreg_q[1];
                  end
               end
               default: begin
                  // IDLE, or PAR with no new word: sit idle and offer ready
                  state_q  <= S_IDLE;
                  x_q      <= 1'b0;
                  active_q <= 1'b0;
                  slot_q   <= 1'b0;
                  ready_q  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign din_ready    = ready_q;
   assign x            = x_q;
   assign frame_active = active_q;
   assign parity_slot  = slot_q;
   assign frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_serializer
// Description : Directed bench for parity_frame_serializer. An even-parity
//               and an odd-parity instance share clock and stimulus, and each
//               serial bit, strobe and parity value is compared against
//               hand-computed expectations. SER_IDLE_GAP_EN selects the
//               gapped expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_serializer;

`ifdef SER_IDLE_GAP_EN
   localparam logic C_PAR_READY = 1'b0;
`else
   localparam logic C_PAR_READY = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;

   logic ready_e, x_e, active_e, slot_e, done_e;
   logic ready_o, x_o, active_o, slot_o, done_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   parity_frame_serializer #(.DATA_W(8), .PARITY_ODD(0)) u_dut_even (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(ready_e), .x(x_e), .frame_active(active_e),
      .parity_slot(slot_e), .frame_done(done_e)
   );

   parity_frame_serializer #(.DATA_W(8), .PARITY_ODD(1)) u_dut_odd (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(ready_o), .x(x_o), .frame_active(active_o),
      .parity_slot(slot_o), .frame_done(done_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Eight data-bit cycles; optionally wiggles din/din_valid with another word
   task automatic shift_bits(input string tag, input logic [7:0] bits, input bit toggle,
                             input logic [7:0] alt, input bit first_done);
      for (int i = 0; i < 8; i++) begin
         check_eq({tag, " x_even"}, {31'd0, x_e}, {31'd0, bits[i]});
         check_eq({tag, " x_odd"}, {31'd0, x_o}, {31'd0, bits[i]});
         check_eq({tag, " active"}, {31'd0, active_e}, 32'd1);
         check_eq({tag, " slot"}, {31'd0, slot_e}, 32'd0);
         check_eq({tag, " ready"}, {31'd0, ready_e}, 32'd0);
         check_eq({tag, " done"}, {31'd0, done_e}, (i == 0) ? {31'd0, first_done} : 32'd0);
         if (toggle) begin
            din       = alt;
            din_valid = (i % 2) == 1;
         end
         tick();
      end
      if (toggle) din_valid = 1'b0;
   endtask

   task automatic check_par(input string tag, input logic pe, input logic po);
      check_eq({tag, " par_even"}, {31'd0, x_e}, {31'd0, pe});
      check_eq({tag, " par_odd"}, {31'd0, x_o}, {31'd0, po});
      check_eq({tag, " par_slot"}, {30'd0, slot_e, slot_o}, 32'd3);
      check_eq({tag, " par_active"}, {30'd0, active_e, active_o}, 32'd3);
      check_eq({tag, " par_ready"}, {31'd0, ready_e}, {31'd0, C_PAR_READY});
      check_eq({tag, " par_done"}, {31'd0, done_e}, 32'd0);
   endtask

   task automatic check_idle(input string tag, input logic done);
      check_eq({tag, " idle_x"}, {30'd0, x_e, x_o}, 32'd0);
      check_eq({tag, " idle_active"}, {30'd0, active_e, active_o}, 32'd0);
      check_eq({tag, " idle_slot"}, {31'd0, slot_e}, 32'd0);
      check_eq({tag, " idle_done"}, {30'd0, done_e, done_o}, {30'd0, done, done});
      check_eq({tag, " idle_ready"}, {30'd0, ready_e, ready_o}, 32'd3);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] word,
                             input logic pe, input logic po);
      din       = word;
      din_valid = 1'b1;
      check_eq({tag, " ready_before"}, {31'd0, ready_e}, 32'd1);
      tick();
      din_valid = 1'b0;
      shift_bits(tag, word, 1'b0, 8'h00, 1'b0);
      check_par(tag, pe, po);
      tick();
      check_idle(tag, 1'b1);
      tick();
      check_idle({tag, "_after"}, 1'b0);
   endtask

   initial begin
      // Reset, including din_valid asserted while reset is low
      tick();
      tick();
      check_eq("rst_outputs", {27'd0, ready_e, x_e, active_e, slot_e, done_e}, 32'd0);
      din       = 8'h5A;
      din_valid = 1'b1;
      tick();
      check_eq("rst_valid_ignored", {30'd0, active_e, ready_e}, 32'd0);
      din_valid = 1'b0;
      reset     = 1'b1;
      tick();
      check_eq("rst_release_ready", {30'd0, ready_e, ready_o}, 32'd3);
      check_eq("rst_release_x", {31'd0, x_e}, 32'd0);

      // Single frames: A5 (4 ones), 07 (3 ones), 00 (0 ones)
      send_frame("a5", 8'hA5, 1'b0, 1'b1);
      send_frame("07", 8'h07, 1'b1, 1'b0);
      send_frame("00", 8'h00, 1'b0, 1'b1);

      // Back-to-back A5 then 3C with din_valid held high
      din       = 8'hA5;
      din_valid = 1'b1;
      check_eq("b2b ready_before", {31'd0, ready_e}, 32'd1);
      tick();
      din = 8'h3C;
      shift_bits("b2b_a5", 8'hA5, 1'b0, 8'h00, 1'b0);
      check_par("b2b_a5", 1'b0, 1'b1);
      tick();
`ifdef SER_IDLE_GAP_EN
      check_idle("b2b_gap", 1'b1);
      tick();
      din_valid = 1'b0;
      shift_bits("b2b_3c", 8'h3C, 1'b0, 8'h00, 1'b0);
`else
      din_valid = 1'b0;
      shift_bits("b2b_3c", 8'h3C, 1'b0, 8'h00, 1'b1);
`endif
      check_par("b2b_3c", 1'b0, 1'b1);
      tick();
      check_idle("b2b_end", 1'b1);
      tick();

      // Reset while the 4th data bit of FF is on x
      din       = 8'hFF;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("abort_bits", {31'd0, x_e}, 32'd1);
         tick();
      end
      check_eq("abort_bit3", {31'd0, x_e}, 32'd1);
      reset = 1'b0;
      tick();
      check_eq("abort_outputs", {27'd0, ready_e, x_e, active_e, slot_e, done_e}, 32'd0);
      reset = 1'b1;
      tick();
      check_eq("abort_release", {27'd0, ready_e, x_e, active_e, slot_e, done_e}, 32'd16);
      send_frame("01", 8'h01, 1'b1, 1'b0);

      // din/din_valid wiggled during SHIFT must not disturb the frame
      din       = 8'h07;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      shift_bits("toggle", 8'h07, 1'b1, 8'hF0, 1'b0);
      check_par("toggle", 1'b1, 1'b0);
      tick();
      check_idle("toggle_end", 1'b1);
      tick();
      check_idle("toggle_quiet", 1'b0);
      send_frame("f0", 8'hF0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/parity_frame_serializer.md
Name: parity_frame_serializer

Overview:
- Upstream stage of the parity checker: converts parallel words into the serial bit stream `x` that the Moore parity checker consumes.
- Accepts one DATA_W-bit word per frame over a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- Appends a computed parity bit after the data bits, so the downstream checker can validate each frame.
- Provides frame framing strobes so a bench can correlate checker output with frame boundaries.

Parameters:
- DATA_W, 8, data bits per frame; legal range 2..32.
- PARITY_ODD, 0, 0 = even parity (total ones in data+parity is even); 1 = odd parity.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- din  input  DATA_W  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block accepts din this cycle when din_valid is also high.
- x  output  1  serial bit stream to the parity checker; registered.
- frame_active  output  1  high while x carries a data or parity bit.
- parity_slot  output  1  high during the cycle x carries the parity bit.
- frame_done  output  1  one-cycle pulse in the cycle after the parity bit is driven.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State becomes IDLE; x=0, frame_active=0, parity_slot=0, frame_done=0, din_ready=0.
  - din_ready goes to 1 on the first edge with reset=1.
- Handshake:
  - Accept happens when din_valid && din_ready are both high at a clk edge.
  - din is captured into the shift register on that edge; din may change afterwards.
- States:
  - IDLE
    - din_ready=1, x=0, frame_active=0.
    - On accept: go to SHIFT, bit counter=0, running parity=0.
  - SHIFT
    - x = shreg[0]; frame_active=1; din_ready=0.
    - Each edge: shreg shifts right, running parity ^= shreg[0], counter++.
    - When the counter reaches DATA_W-1 at an edge: go to PAR.
  - PAR
    - x = running parity ^ PARITY_ODD; parity_slot=1; frame_active=1; din_ready=1.
    - Accept in PAR: go straight to SHIFT with the new word (back-to-back frames, no gap); frame_done pulses in the next cycle.
    - No accept in PAR: go to IDLE; frame_done pulses in the next cycle.
- Latency:
  - Bit 0 of din appears on x in the cycle after the accept edge.
  - The parity bit appears DATA_W cycles after that.
  - Frame length is DATA_W+1 cycles.
- din_valid in SHIFT is ignored. The word is held upstream, with no drop and no overwrite.
- Reset mid-frame: the frame is aborted at that edge. No frame_done and no parity bit are emitted. x=0 from the next cycle.
- din_valid asserted together with reset=0: ignored.
- Counter width is clog2(DATA_W). The counter does not wrap within a frame.

Optional Feature:
- Macro: SER_IDLE_GAP_EN.
- Defined:
  - din_ready is low in PAR.
  - After PAR the block spends exactly one IDLE cycle with x=0 and din_ready=1 before it can accept.
  - Frames are separated by at least one idle bit, which gives the downstream Moore checker a settle cycle.
- Not defined:
  - Back-to-back acceptance in PAR as specified in Behaviour.

Test Plan:
- Even parity, din=8'hA5 held valid one cycle after reset release -> x = 1,0,1,0,0,1,0,1 then parity 0; parity_slot high only on the 9th bit; frame_done pulses once.
- Even parity, din=8'h07 -> x = 1,1,1,0,0,0,0,0 then parity 1; downstream checker parity agrees with the final frame bit.
- PARITY_ODD=1, din=8'hA5 -> parity bit 1; din=8'h00 -> parity bit 1.
- Back-to-back (macro undefined): din_valid held high with 8'hA5 then 8'h3C -> 18 contiguous active bits, second word starting the cycle after the first parity bit, din_ready high exactly in IDLE and the two PAR cycles; with SER_IDLE_GAP_EN -> one x=0 cycle between frames.
- Reset asserted at the 4th data bit of 8'hFF -> next cycle x=0, frame_active=0, no frame_done; a new word 8'h01 after release -> x = 1,0,0,0,0,0,0,0 with parity 1.
- din_valid toggled during SHIFT with a different word -> ignored; the in-flight frame is unchanged and the new word is accepted only when din_ready=1.
